framebuffer_scan_reader: RTL
============================

Name: framebuffer_scan_reader

Overview:
- Read-side consumer of the dual-port framebuffer: owns `read_addr` and `q` of the 160x120 1-bit buffer.
- Generates 640x480 VGA raster timing and scans the framebuffer with 4x pixel/line replication.
- Compensates for RAM read latency so pixel, sync and blank leave the block cycle-aligned.
- Sits between the framebuffer read port and the VGA output pins, clocked by the pixel clock.

Parameters:
- DATA_WIDTH, 1: framebuffer word width.
- ADDR_WIDTH, 15: framebuffer address width.
- FB_WIDTH, 160: framebuffer columns.
- FB_HEIGHT, 120: framebuffer rows.
- SCALE_SHIFT, 2: log2 of the replication factor; H_ACTIVE must equal FB_WIDTH<<SCALE_SHIFT, V_ACTIVE must equal FB_HEIGHT<<SCALE_SHIFT.
- H_ACTIVE / H_FP / H_SYNC / H_BP, 640 / 16 / 96 / 48: horizontal timing in clocks.
- V_ACTIVE / V_FP / V_SYNC / V_BP, 480 / 10 / 2 / 33: vertical timing in lines.
- SYNC_POL, 0: sync active level (0 = active-low).
- RAM_LATENCY, 1: clocks from `read_addr` sampled to `q` valid.

Ports:
- clock  in  1  pixel clock; same clock as the framebuffer read port.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  scan request; sampled only at frame boundaries.
- read_addr  out  ADDR_WIDTH  framebuffer read address, registered.
- q  in  DATA_WIDTH  framebuffer read data.
- pixel  out  DATA_WIDTH  pixel value, registered; forced to 0 when blank=1.
- hsync  out  1  horizontal sync, registered, SYNC_POL active.
- vsync  out  1  vertical sync, registered, SYNC_POL active.
- blank  out  1  1 outside the active area or when idle.
- frame_start  out  1  one-cycle pulse aligned with output pixel (0,0).

Behaviour:
- Reset values: read_addr=0, pixel=0, hsync=vsync=~SYNC_POL, blank=1, frame_start=0, h/v counters=0, state=IDLE, all pipeline stages cleared to the blanked/inactive values.
- Reset takes effect immediately and asynchronously at any point, including mid-frame. After reset release the block restarts from IDLE with no partial-frame output.
- Counters:
  - H_TOTAL = sum of the H_* values (800); V_TOTAL = sum of the V_* values (525).
  - h increments each clock in SCAN and wraps at H_TOTAL-1.
  - v increments on the h wrap and wraps at V_TOTAL-1.
- State machine:
  - IDLE: counters held at 0. Moves to SCAN on the first clock with enable=1.
  - SCAN: at h=H_TOTAL-1, v=V_TOTAL-1, continues if enable=1, otherwise goes to IDLE.
  - Deasserting enable mid-frame has no effect until the frame completes.
- Raster decode, for counter value (h,v):
  - active = h<H_ACTIVE and v<V_ACTIVE.
  - hsync active for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC.
  - vsync active for V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC.
- Address generation:
  - read_addr = (v>>SCALE_SHIFT)*FB_WIDTH + (h>>SCALE_SHIFT), registered one cycle after the counter is at (h,v).
  - Computed incrementally, with no multiplier: a row-base register adds FB_WIDTH every 2^SCALE_SHIFT active lines and clears at v wrap.
  - Outside the active area read_addr holds its last value.
  - read_addr never exceeds FB_WIDTH*FB_HEIGHT-1 (19199).
- Alignment:
  - pixel, hsync, vsync, blank and frame_start for counter (h,v) all appear on the same output cycle, exactly 2+RAM_LATENCY clocks (3 by default) after the counter is at (h,v).
  - Sync/blank are delayed through a shift pipeline matching the RAM path.
- In IDLE and during pipeline drain after IDLE entry, outputs progress to the blanked/inactive values; pixel stays 0.
- frame_start is asserted only for the (0,0) pixel of frames started in SCAN.

Test Plan:
1. Reset then enable=1 with the framebuffer model returning q = addr[0] at latency 1 -> first frame_start 3 clocks after entering SCAN; blank=0 for 640 clocks per line; hsync low for exactly 96 clocks beginning 16 clocks after blank rises; line period 800 clocks.
2. Monitor read_addr over one frame -> each value 0..19199 presented for exactly 4 consecutive active clocks on each of 4 consecutive lines; row 1 starts at line 4 with address 160; address 19199 is the last value and is never exceeded.
3. Vertical timing -> vsync low for exactly 2 lines starting at line 490; frame period 420000 clocks; blank=1 for all lines 480-524.
4. Framebuffer preloaded with the rectangle (x 40-119, y 30-89 = 0, else 1) -> pixel=0 exactly for output h 160-479, v 120-359; pixel=1 elsewhere in the active area; pixel=0 whenever blank=1.
5. Drop enable mid-frame -> current frame completes intact; no further frame_start; outputs settle to blank=1, hsync=vsync=1 within 3 clocks of the last frame cycle. Reassert enable -> new frame_start 3 clocks later.
6. Assert reset_n=0 mid-line -> outputs take reset values with no clock edge; after release with enable=1, the first frame_start arrives 3 clocks after SCAN entry.

Source files
------------

// File: rtl/framebuffer_scan_reader.sv
// Scans a 1-bit framebuffer with pixel/line replication and produces VGA raster timing.
// Address, RAM data, sync and blank paths are delayed so they leave the block cycle-aligned.
module framebuffer_scan_reader #(
  parameter int       DATA_WIDTH  = 1,
  parameter int       ADDR_WIDTH  = 15,
  parameter int       FB_WIDTH    = 160,
  parameter int       FB_HEIGHT   = 120,
  parameter int       SCALE_SHIFT = 2,
  parameter int       H_ACTIVE    = 640,
  parameter int       H_FP        = 16,
  parameter int       H_SYNC      = 96,
  parameter int       H_BP        = 48,
  parameter int       V_ACTIVE    = 480,
  parameter int       V_FP        = 10,
  parameter int       V_SYNC      = 2,
  parameter int       V_BP        = 33,
  parameter logic     SYNC_POL    = 1'b0,
  parameter int       RAM_LATENCY = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  enable,
  output logic [ADDR_WIDTH-1:0] read_addr,
  input  logic [DATA_WIDTH-1:0] q,
  output logic [DATA_WIDTH-1:0] pixel,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  blank,
  output logic                  frame_start,
  output logic                  scan_state
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_W     = $clog2(H_TOTAL);
  localparam int V_W     = $clog2(V_TOTAL);

  localparam logic [H_W-1:0] H_LAST     = H_W'(H_TOTAL - 1);
  localparam logic [H_W-1:0] H_ACT      = H_W'(H_ACTIVE);
  localparam logic [H_W-1:0] H_SYNC_ON  = H_W'(H_ACTIVE + H_FP);
  localparam logic [H_W-1:0] H_SYNC_OFF = H_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [V_W-1:0] V_LAST     = V_W'(V_TOTAL - 1);
  localparam logic [V_W-1:0] V_ACT      = V_W'(V_ACTIVE);
  localparam logic [V_W-1:0] V_SYNC_ON  = V_W'(V_ACTIVE + V_FP);
  localparam logic [V_W-1:0] V_SYNC_OFF = V_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [V_W-1:0] V_ROW_LAST = V_W'((FB_HEIGHT << SCALE_SHIFT) - 1);
  localparam logic [V_W-1:0] V_REP_MASK = V_W'((1 << SCALE_SHIFT) - 1);

  typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

  state_t                  state, state_next;
  logic                    scanning;
  logic [H_W-1:0]          h_cnt;
  logic [V_W-1:0]          v_cnt;
  logic [ADDR_WIDTH-1:0]   row_base;
  logic                    frame_end;
  logic                    act_now, hs_now, vs_now, fs_now;
  logic [RAM_LATENCY:0]    act_pipe, hs_pipe, vs_pipe, fs_pipe;

  assign frame_end = (h_cnt == H_LAST) && (v_cnt == V_LAST);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // enable only matters in IDLE and on the last cycle of a frame
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (enable) state_next = SCAN;
      SCAN: if (frame_end && !enable) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    scanning   = (state == SCAN);
    scan_state = scanning;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!scanning) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  always_comb begin
    act_now = scanning && (h_cnt < H_ACT) && (v_cnt < V_ACT);
    hs_now  = scanning && (h_cnt >= H_SYNC_ON) && (h_cnt < H_SYNC_OFF);
    vs_now  = scanning && (v_cnt >= V_SYNC_ON) && (v_cnt < V_SYNC_OFF);
    fs_now  = scanning && (h_cnt == '0) && (v_cnt == '0);
  end

  // Row base steps one framebuffer row after the last replicated line of each row.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      row_base <= '0;
    end else if (!scanning) begin
      row_base <= '0;
    end else if (h_cnt == H_LAST) begin
      if (v_cnt == V_LAST)
        row_base <= '0;
      else if ((v_cnt < V_ROW_LAST) && ((v_cnt & V_REP_MASK) == V_REP_MASK))
        row_base <= row_base + ADDR_WIDTH'(FB_WIDTH);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)     read_addr <= '0;
    else if (act_now) read_addr <= row_base + ADDR_WIDTH'(h_cnt >> SCALE_SHIFT);
  end

  // Stage 0 lines up with read_addr; stage RAM_LATENCY lines up with q.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      act_pipe <= '0;
      hs_pipe  <= '0;
      vs_pipe  <= '0;
      fs_pipe  <= '0;
    end else begin
      act_pipe[0] <= act_now;
      hs_pipe[0]  <= hs_now;
      vs_pipe[0]  <= vs_now;
      fs_pipe[0]  <= fs_now;
      for (int i = 1; i <= RAM_LATENCY; i++) begin
        act_pipe[i] <= act_pipe[i-1];
        hs_pipe[i]  <= hs_pipe[i-1];
        vs_pipe[i]  <= vs_pipe[i-1];
        fs_pipe[i]  <= fs_pipe[i-1];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pixel       <= '0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      blank       <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      pixel       <= act_pipe[RAM_LATENCY] ? q : '0;
      hsync       <= hs_pipe[RAM_LATENCY] ? SYNC_POL : ~SYNC_POL;
      vsync       <= vs_pipe[RAM_LATENCY] ? SYNC_POL : ~SYNC_POL;
      blank       <= ~act_pipe[RAM_LATENCY];
      frame_start <= fs_pipe[RAM_LATENCY];
    end
  end

endmodule
